t1_decode: RTL and testbench

//  ML-DSA verify-side inverse of power2round pk packing: reads the packed t1 field of the public key
//  (10-bit coefficients) from the 32-bit API register space and writes t1*2^13 into main memory,
//  4 coefficients per memory word. Sits between the pk API registers and the NTT memory at verify start.

---
 rtl/power2round_defines_pkg.sv | 44 ++++
 rtl/t1_decode_gearbox.sv | 57 +++++
 rtl/t1_decode.sv | 179 +++++++++++++++++
 tb/tb_t1_decode.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power2round_defines_pkg.sv
// Shared types, sizes and the t1 coefficient expansion used by the verify-side t1 unpacker.
package power2round_defines_pkg;

  localparam int MLDSA_K      = 8;
  localparam int PK_ADDR_W    = 10;
  localparam int MEM_ADDR_W   = 15;
  localparam int PK_T1_OFFSET = 8;
  localparam int COEFF_W      = 24;

  localparam int T1_COEFF_W   = 10;
  localparam int T1_SHIFT     = 13;
  localparam int T1_API_WORDS = 640;
  localparam int T1_MEM_WORDS = 512;

  localparam int GB_PUSH_W = 32;
  localparam int GB_POP_W  = 4 * T1_COEFF_W;
  localparam int GB_W      = 80;
  localparam int GB_CNT_W  = 7;

  typedef enum logic [1:0] {
    T1_RD_IDLE = 2'd0,
    T1_RD_API  = 2'd1,
    T1_RD_DONE = 2'd2
  } t1_decode_read_state_type;

  typedef enum logic [1:0] {
    T1_WR_IDLE = 2'd0,
    T1_WR_MEM  = 2'd1,
    T1_WR_DONE = 2'd2
  } t1_decode_write_state_type;

  // Four 10-bit t1 values become four t1*2^13 memory coefficients, c0 in the LSBs.
  function automatic logic [4*COEFF_W-1:0] t1_expand(input logic [GB_POP_W-1:0] pc);
    logic [4*COEFF_W-1:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w[k*COEFF_W +: COEFF_W] = {{(COEFF_W-T1_COEFF_W-T1_SHIFT){1'b0}},
                                 pc[k*T1_COEFF_W +: T1_COEFF_W],
                                 {T1_SHIFT{1'b0}}};
    end
    return w;
  endfunction

endpackage

// File: rtl/t1_decode_gearbox.sv
// 32-bit push / 40-bit pop bit gearbox over an 80-bit buffer, LSB-first stream order.
module t1_decode_gearbox
  import power2round_defines_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push,
  input  logic [GB_PUSH_W-1:0] push_data,
  input  logic                pop,
  output logic [GB_POP_W-1:0] pop_data,
  output logic [GB_CNT_W-1:0] count,
  output logic                can_pop,
  output logic                empty
);

  logic [GB_W-1:0]     data_q, data_d;
  logic [GB_CNT_W-1:0] cnt_q, cnt_d;
  logic [GB_W-1:0]     kept;
  logic [GB_CNT_W-1:0] kept_cnt;

  // Pop is applied first so a same-cycle push lands right above the surviving bits.
  always_comb begin
    kept     = data_q;
    kept_cnt = cnt_q;
    if (pop) begin
      kept     = data_q >> GB_POP_W;
      kept_cnt = cnt_q - GB_CNT_W'(GB_POP_W);
    end
    data_d = kept;
    cnt_d  = kept_cnt;
    if (push) begin
      data_d = kept | ({{(GB_W-GB_PUSH_W){1'b0}}, push_data} << kept_cnt);
      cnt_d  = kept_cnt + GB_CNT_W'(GB_PUSH_W);
    end
    if (clear) begin
      data_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop_data = data_q[GB_POP_W-1:0];
  assign count    = cnt_q;
  assign can_pop  = (cnt_q >= GB_CNT_W'(GB_POP_W));
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/t1_decode.sv
// Unpacks the 10-bit t1 field of the public key from the API registers into memory as t1*2^13.
// Handshake: pk_rd_data is valid exactly one cycle after pk_rd_en; memory writes are fire-and-forget.
module t1_decode
  import power2round_defines_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      zeroize,
  input  logic                      t1_decode_en,
  input  logic [MEM_ADDR_W-1:0]     dest_base_addr,
  output logic                      pk_rd_en,
  output logic [PK_ADDR_W-1:0]      pk_rd_addr,
  input  logic [31:0]               pk_rd_data,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_W-1:0]     mem_wr_addr,
  output logic [4*COEFF_W-1:0]      mem_wr_data,
  output logic                      t1_decode_done,
  output t1_decode_read_state_type  dbg_rd_state,
  output t1_decode_write_state_type dbg_wr_state,
  output logic [GB_CNT_W-1:0]       dbg_buf_count
);

  t1_decode_read_state_type  rd_state_q, rd_state_d;
  t1_decode_write_state_type wr_state_q, wr_state_d;
  logic [9:0]              rd_cnt_q, rd_cnt_d;
  logic [PK_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                    inflight_q, inflight_d;
  logic [MEM_ADDR_W-1:0]   dest_base_q, dest_base_d;
  logic [8:0]              wr_cnt_q, wr_cnt_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [MEM_ADDR_W-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [4*COEFF_W-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic                    done_q, done_d;

  logic                    start;
  logic                    rd_issue;
  logic                    gb_pop;
  logic [GB_POP_W-1:0]     gb_pop_data;
  logic [GB_CNT_W-1:0]     gb_count;
  logic                    gb_can_pop;
  logic                    gb_empty;

  assign start = t1_decode_en && (rd_state_q == T1_RD_IDLE) && (wr_state_q == T1_WR_IDLE);

  // A read is only issued when the buffer can absorb it plus any word still in flight.
  assign rd_issue = !zeroize && (rd_state_q == T1_RD_API) &&
                    (({1'b0, gb_count} + (inflight_q ? 8'd32 : 8'd0)) <= 8'd48);
  assign gb_pop   = (wr_state_q == T1_WR_MEM) && gb_can_pop;

  always_comb begin
    rd_state_d    = rd_state_q;
    wr_state_d    = wr_state_q;
    rd_cnt_d      = rd_cnt_q;
    rd_addr_d     = rd_addr_q;
    inflight_d    = rd_issue;
    dest_base_d   = dest_base_q;
    wr_cnt_d      = wr_cnt_q;
    mem_wr_en_d   = gb_pop;
    mem_wr_addr_d = '0;
    mem_wr_data_d = '0;
    done_d        = 1'b0;

    case (rd_state_q)
      T1_RD_IDLE: begin
        if (start) begin
          rd_state_d  = T1_RD_API;
          rd_cnt_d    = '0;
          rd_addr_d   = PK_ADDR_W'(PK_T1_OFFSET);
          dest_base_d = dest_base_addr;
        end
      end
      T1_RD_API: begin
        if (rd_issue) begin
          rd_cnt_d  = rd_cnt_q + 10'd1;
          rd_addr_d = rd_addr_q + PK_ADDR_W'(1);
          if (rd_cnt_q == 10'(T1_API_WORDS - 1)) rd_state_d = T1_RD_DONE;
        end
      end
      T1_RD_DONE: begin
        if (wr_state_q == T1_WR_DONE) rd_state_d = T1_RD_IDLE;
      end
      default: rd_state_d = T1_RD_IDLE;
    endcase

    case (wr_state_q)
      T1_WR_IDLE: begin
        if (start) begin
          wr_state_d = T1_WR_MEM;
          wr_cnt_d   = '0;
        end
      end
      T1_WR_MEM: begin
        if (gb_pop) begin
          mem_wr_addr_d = dest_base_q + MEM_ADDR_W'(wr_cnt_q);
          mem_wr_data_d = t1_expand(gb_pop_data);
          wr_cnt_d      = wr_cnt_q + 9'd1;
          if (wr_cnt_q == 9'(T1_MEM_WORDS - 1)) wr_state_d = T1_WR_DONE;
        end
      end
      T1_WR_DONE: begin
        done_d     = 1'b1;
        wr_state_d = T1_WR_IDLE;
      end
      default: wr_state_d = T1_WR_IDLE;
    endcase

    if (zeroize) begin
      rd_state_d    = T1_RD_IDLE;
      wr_state_d    = T1_WR_IDLE;
      rd_cnt_d      = '0;
      rd_addr_d     = '0;
      inflight_d    = 1'b0;
      dest_base_d   = '0;
      wr_cnt_d      = '0;
      mem_wr_en_d   = 1'b0;
      mem_wr_addr_d = '0;
      mem_wr_data_d = '0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q    <= T1_RD_IDLE;
      wr_state_q    <= T1_WR_IDLE;
      rd_cnt_q      <= '0;
      rd_addr_q     <= '0;
      inflight_q    <= 1'b0;
      dest_base_q   <= '0;
      wr_cnt_q      <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_addr_q     <= rd_addr_d;
      inflight_q    <= inflight_d;
      dest_base_q   <= dest_base_d;
      wr_cnt_q      <= wr_cnt_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
    end
  end

  // Data returning for a read issued last cycle is pushed; zeroize clears it away.
  t1_decode_gearbox u_gearbox (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (zeroize),
    .push      (inflight_q),
    .push_data (pk_rd_data),
    .pop       (gb_pop),
    .pop_data  (gb_pop_data),
    .count     (gb_count),
    .can_pop   (gb_can_pop),
    .empty     (gb_empty)
  );

  assign pk_rd_en       = rd_issue;
  assign pk_rd_addr     = rd_addr_q;
  assign mem_wr_en      = mem_wr_en_q;
  assign mem_wr_addr    = mem_wr_addr_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign t1_decode_done = done_q;
  assign dbg_rd_state   = rd_state_q;
  assign dbg_wr_state   = wr_state_q;
  assign dbg_buf_count  = gb_count;

  a_buf_bound: assert property (@(posedge clk) disable iff (!reset_n)
    gb_count <= GB_CNT_W'(GB_W));
  a_empty_at_done: assert property (@(posedge clk) disable iff (!reset_n)
    (wr_state_q == T1_WR_DONE) |-> gb_empty);

endmodule

// File: tb/tb_t1_decode.sv
// Bench for t1_decode: API register model, byte-stream reference model and write scoreboard.
module tb_t1_decode;
  import power2round_defines_pkg::*;

  logic                      clk;
  logic                      reset_n;
  logic                      zeroize;
  logic                      t1_decode_en;
  logic [MEM_ADDR_W-1:0]     dest_base_addr;
  logic                      pk_rd_en;
  logic [PK_ADDR_W-1:0]      pk_rd_addr;
  logic [31:0]               pk_rd_data;
  logic                      mem_wr_en;
  logic [MEM_ADDR_W-1:0]     mem_wr_addr;
  logic [4*COEFF_W-1:0]      mem_wr_data;
  logic                      t1_decode_done;
  t1_decode_read_state_type  dbg_rd_state;
  t1_decode_write_state_type dbg_wr_state;
  logic [GB_CNT_W-1:0]       dbg_buf_count;

  t1_decode dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .zeroize        (zeroize),
    .t1_decode_en   (t1_decode_en),
    .dest_base_addr (dest_base_addr),
    .pk_rd_en       (pk_rd_en),
    .pk_rd_addr     (pk_rd_addr),
    .pk_rd_data     (pk_rd_data),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .t1_decode_done (t1_decode_done),
    .dbg_rd_state   (dbg_rd_state),
    .dbg_wr_state   (dbg_wr_state),
    .dbg_buf_count  (dbg_buf_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- API register model ----------------
  logic [31:0] pk_mem [0:1023];

  always @(posedge clk) begin
    if (pk_rd_en) pk_rd_data <= pk_mem[pk_rd_addr];
    else          pk_rd_data <= $urandom;
  end

  // ---------------- reference model ----------------
  logic [4*COEFF_W-1:0]  exp_q[$];
  logic [MEM_ADDR_W-1:0] exp_addr_q[$];

  // coefficient i = bits [10i+9:10i] of the little-endian byte stream starting at word 8
  function automatic logic [9:0] coeff_of(input int i);
    logic [9:0] c;
    logic [7:0] b;
    int n;
    for (int k = 0; k < 10; k++) begin
      n    = 10 * i + k;
      b    = 8'(pk_mem[PK_T1_OFFSET + (n / 8) / 4] >> (8 * ((n / 8) % 4)));
      c[k] = b[n % 8];
    end
    return c;
  endfunction

  task automatic build_expected(input logic [MEM_ADDR_W-1:0] base);
    logic [4*COEFF_W-1:0] d;
    exp_q.delete();
    exp_addr_q.delete();
    for (int w = 0; w < 512; w++) begin
      for (int k = 0; k < 4; k++) d[24*k +: 24] = 24'(coeff_of(4 * w + k)) * 24'd8192;
      exp_q.push_back(d);
      exp_addr_q.push_back(MEM_ADDR_W'(base + MEM_ADDR_W'(w)));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic fill_words(input int mode);
    for (int a = 0; a < 1024; a++) pk_mem[a] = $urandom;
    for (int a = PK_T1_OFFSET; a < PK_T1_OFFSET + 640; a++) begin
      if (mode == 0)      pk_mem[a] = 32'h0;
      else if (mode == 1) pk_mem[a] = 32'hFFFF_FFFF;
      else                pk_mem[a] = $urandom;
    end
  endtask

  task automatic fill_ramp();
    logic [9:0] v;
    int n;
    fill_words(2);
    for (int p = 0; p < MLDSA_K; p++) begin
      for (int j = 0; j < 256; j++) begin
        v = 10'((j + 256 * (p % 4)) % 1024);
        for (int k = 0; k < 10; k++) begin
          n = 10 * (256 * p + j) + k;
          pk_mem[PK_T1_OFFSET + n / 32][n % 32] = v[k];
        end
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic                  mon_on = 1'b0;
  logic                  const_mode = 1'b0;
  int                    rd_seen, wr_seen, done_cnt;
  logic [PK_ADDR_W-1:0]  rd_exp_addr;
  logic [4*COEFF_W-1:0]  m_data;
  logic [MEM_ADDR_W-1:0] m_addr;

  always @(negedge clk) begin
    if (mon_on) begin
      check("buf_count_le_80", 128'(dbg_buf_count <= 7'd80), 128'd1);
      if (pk_rd_en) begin
        check("rd_addr", 128'(pk_rd_addr), 128'(rd_exp_addr));
        rd_exp_addr = rd_exp_addr + 1'b1;
        rd_seen++;
      end
      if (mem_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 128'd1, 128'd0);
        end else begin
          m_data = exp_q.pop_front();
          m_addr = exp_addr_q.pop_front();
          check("wr_addr", 128'(mem_wr_addr), 128'(m_addr));
          check("wr_data", 128'(mem_wr_data), 128'(m_data));
        end
        if (const_mode) check("wr_all_ones", 128'(mem_wr_data), 128'({4{24'h7FE000}}));
        wr_seen++;
      end
      if (t1_decode_done) begin
        done_cnt++;
        check("done_after_last_write", 128'(wr_seen), 128'd512);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [MEM_ADDR_W-1:0] base);
    build_expected(base);
    rd_exp_addr = PK_ADDR_W'(PK_T1_OFFSET);
    rd_seen  = 0;
    wr_seen  = 0;
    done_cnt = 0;
    mon_on   = 1'b1;
    @(posedge clk); #1;
    dest_base_addr = base;
    t1_decode_en   = 1'b1;
    @(posedge clk); #1;
    t1_decode_en   = 1'b0;
    dest_base_addr = MEM_ADDR_W'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_no_timeout"}, 128'(cyc < 4000), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 128'(done_cnt), 128'd1);
    check({tag, "_reads"}, 128'(rd_seen), 128'd640);
    check({tag, "_writes"}, 128'(wr_seen), 128'd512);
    check({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
    check({tag, "_buf_empty"}, 128'(dbg_buf_count), 128'd0);
    check({tag, "_rd_idle"}, 128'(dbg_rd_state), 128'(T1_RD_IDLE));
    check({tag, "_wr_idle"}, 128'(dbg_wr_state), 128'(T1_WR_IDLE));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"}, 128'(pk_rd_en), 128'd0);
    check({tag, "_wr_en"}, 128'(mem_wr_en), 128'd0);
    check({tag, "_wr_data"}, 128'(mem_wr_data), 128'd0);
    check({tag, "_done"}, 128'(t1_decode_done), 128'd0);
    check({tag, "_buf_count"}, 128'(dbg_buf_count), 128'd0);
  endtask

  task automatic wait_count(input string tag, input int which, input int target);
    int cyc;
    cyc = 0;
    while (((which == 0) ? rd_seen : wr_seen) < target && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_reached"}, 128'(cyc < 4000), 128'd1);
  endtask

  // ---------------- test sequence ----------------
  int snap;

  initial begin
    reset_n        = 1'b0;
    zeroize        = 1'b0;
    t1_decode_en   = 1'b0;
    dest_base_addr = '0;
    fill_words(0);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_rd_addr", 128'(pk_rd_addr), 128'd0);
    check("reset_wr_addr", 128'(mem_wr_addr), 128'd0);
    reset_n = 1'b1;

    // all-zero field
    fill_words(0);
    start_run(MEM_ADDR_W'($urandom));
    wait_done("zero");

    // all-ones field
    fill_words(1);
    const_mode = 1'b1;
    start_run(MEM_ADDR_W'($urandom));
    wait_done("ones");
    const_mode = 1'b0;

    // per-poly ramp, base near the top of the address space to exercise wrap
    fill_ramp();
    start_run(MEM_ADDR_W'(32768 - 100));
    wait_done("ramp");

    // random field with an extra start mid-run
    fill_words(2);
    start_run(MEM_ADDR_W'($urandom));
    repeat ($urandom_range(20, 300)) @(posedge clk);
    #1;
    dest_base_addr = MEM_ADDR_W'($urandom);
    t1_decode_en   = 1'b1;
    @(posedge clk); #1;
    t1_decode_en   = 1'b0;
    wait_done("restart_ignored");

    // zeroize at write 200
    fill_words(2);
    start_run(MEM_ADDR_W'($urandom));
    wait_count("zeroize", 1, 200);
    @(posedge clk); #1;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check_quiet("zeroize");
    exp_q.delete();
    exp_addr_q.delete();
    snap = wr_seen;
    repeat (30) @(posedge clk);
    #1;
    check("zeroize_no_more_writes", 128'(wr_seen), 128'(snap));
    check("zeroize_no_done", 128'(done_cnt), 128'd0);
    fill_words(2);
    start_run(MEM_ADDR_W'($urandom));
    wait_done("after_zeroize");

    // asynchronous reset at read 300
    fill_words(2);
    start_run(MEM_ADDR_W'($urandom));
    wait_count("reset_mid", 0, 300);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_rd_addr", 128'(pk_rd_addr), 128'd0);
    exp_q.delete();
    exp_addr_q.delete();
    snap = wr_seen;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_no_more_writes", 128'(wr_seen), 128'(snap));
    check("reset_no_done", 128'(done_cnt), 128'd0);
    fill_ramp();
    start_run(MEM_ADDR_W'($urandom));
    wait_done("after_reset");

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
